// File: rtl/miss_msg_det_pkg.sv
// Shared types and default widths for the MoldUDP64 missing-message detector.
package miss_msg_det_pkg;

    localparam int DEF_SEQ_NUM_W = 64;
    localparam int DEF_SID_W     = 80;
    localparam int DEF_ML_W      = 16;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_DEPTH     = 4;

    typedef enum logic {
        SEQ = 1'b0,
        SID = 1'b1
    } req_kind_e;

    typedef struct packed {
        req_kind_e                kind;
        logic [DEF_SID_W-1:0]     sid;
        logic [DEF_SEQ_NUM_W-1:0] seq_start;
        logic [DEF_SEQ_NUM_W-1:0] seq_cnt;
        logic [DEF_SID_W-1:0]     sid_cnt;
    } miss_req_t;

endpackage

// File: rtl/miss_req_fifo.sv
// Synchronous FIFO of retransmission-request entries; head is shown on rdata,
// forced to zero while empty so the outputs read clean after reset.
module miss_req_fifo
    import miss_msg_det_pkg::*;
#(
    parameter type T     = miss_req_t,
    parameter int  DEPTH = DEF_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic empty,
    output logic full
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    cnt;
    logic           wr_en;
    logic           rd_en;

    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
    // a write into a full FIFO is legal only when the head leaves on the same edge
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? T'('0) : mem[rd_ptr];

endmodule

// File: rtl/miss_msg_det_q.sv
// MoldUDP64 missing-message detector: classifies each packet header against the
// expected (session, sequence) and queues every hole as a retransmission request.
module miss_msg_det_q
    import miss_msg_det_pkg::*;
#(
    parameter int                   SEQ_NUM_W   = DEF_SEQ_NUM_W,
    parameter int                   SID_W       = DEF_SID_W,
    parameter int                   ML_W        = DEF_ML_W,
    parameter logic [SID_W-1:0]     SID_GAP_MAX = {1'b1, {(SID_W-1){1'b0}}},
    parameter logic [SEQ_NUM_W-1:0] SEQ_INIT    = SEQ_NUM_W'(1),
    parameter int                   DEPTH       = DEF_DEPTH,
    parameter int                   CNT_W       = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 v_i,
    input  logic [SID_W-1:0]     sid_i,
    input  logic [SEQ_NUM_W-1:0] seq_num_i,
    input  logic [ML_W-1:0]      msg_cnt_i,
    input  logic                 eos_i,
    output logic                 req_v_o,
    input  logic                 req_rdy_i,
    output logic                 req_kind_o,
    output logic [SID_W-1:0]     req_sid_o,
    output logic [SEQ_NUM_W-1:0] req_seq_start_o,
    output logic [SEQ_NUM_W-1:0] req_seq_cnt_o,
    output logic [SID_W-1:0]     req_sid_cnt_o,
    output logic [CNT_W-1:0]     dup_cnt_o,
    output logic [CNT_W-1:0]     gap_cnt_o,
    output logic                 drop_o,
    output logic                 err_o
);

    typedef struct packed {
        req_kind_e            kind;
        logic [SID_W-1:0]     sid;
        logic [SEQ_NUM_W-1:0] seq_start;
        logic [SEQ_NUM_W-1:0] seq_cnt;
        logic [SID_W-1:0]     sid_cnt;
    } req_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    logic                 sync_q;
    logic [SID_W-1:0]     sid_q;
    logic [SEQ_NUM_W-1:0] seq_q;

    logic [SEQ_NUM_W:0]   end_w;
    logic [SEQ_NUM_W-1:0] end_s;
    logic                 ovf;
    logic [SID_W-1:0]     sdist;

    logic                 accept;
    logic                 push;
    logic                 dup_inc;
    logic                 gap_inc;
    logic                 err_set;
    logic [SID_W-1:0]     sid_n;
    logic [SEQ_NUM_W-1:0] seq_n;
    req_t                 req;

    req_t                 head;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;

    assign end_w = {1'b0, seq_num_i} + {{(SEQ_NUM_W+1-ML_W){1'b0}}, msg_cnt_i};
    assign end_s = end_w[SEQ_NUM_W-1:0];
    assign ovf   = end_w[SEQ_NUM_W];
    assign sdist = sid_i - sid_q;

    always_comb begin
        accept  = 1'b0;
        push    = 1'b0;
        dup_inc = 1'b0;
        gap_inc = 1'b0;
        err_set = 1'b0;
        sid_n   = sid_q;
        seq_n   = seq_q;
        req     = '0;
        if (v_i) begin
            if (ovf) begin
                err_set = 1'b1;
            end else if (!sync_q) begin
                accept = 1'b1;
                sid_n  = sid_i;
                seq_n  = end_s;
            end else if (sdist != '0 && sdist >= SID_GAP_MAX) begin
                dup_inc = 1'b1;
            end else if (sdist == '0) begin
                accept = 1'b1;
                if (end_s <= seq_q && msg_cnt_i != '0) begin
                    dup_inc = 1'b1;
                end else if (seq_num_i > seq_q) begin
                    push          = 1'b1;
                    gap_inc       = 1'b1;
                    req.kind      = SEQ;
                    req.sid       = sid_q;
                    req.seq_start = seq_q;
                    req.seq_cnt   = seq_num_i - seq_q;
                    seq_n         = end_s;
                end else begin
                    seq_n = (end_s > seq_q) ? end_s : seq_q;
                end
            end else begin
                accept        = 1'b1;
                push          = 1'b1;
                gap_inc       = 1'b1;
                req.kind      = SID;
                req.sid       = sid_q;
                req.seq_start = seq_q;
                req.seq_cnt   = seq_num_i;
                req.sid_cnt   = sdist;
                sid_n         = sid_i;
                seq_n         = end_s;
            end
            // end of session: the next packet is expected at the start of the following session
            if (accept && eos_i) begin
                sid_n = sid_n + SID_W'(1);
                seq_n = SEQ_INIT;
            end
        end
    end

    assign pop = req_v_o && req_rdy_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= 1'b0;
            sid_q     <= '0;
            seq_q     <= SEQ_INIT;
            dup_cnt_o <= '0;
            gap_cnt_o <= '0;
            drop_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            if (accept) begin
                sync_q <= 1'b1;
                sid_q  <= sid_n;
                seq_q  <= seq_n;
            end
            if (dup_inc) dup_cnt_o <= sat_inc(dup_cnt_o);
            if (gap_inc) gap_cnt_o <= sat_inc(gap_cnt_o);
            if (err_set) err_o <= 1'b1;
            if (push && fifo_full && !pop) drop_o <= 1'b1;
        end
    end

    miss_req_fifo #(
        .T     (req_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (req),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign req_v_o         = !fifo_empty;
    assign req_kind_o      = head.kind;
    assign req_sid_o       = head.sid;
    assign req_seq_start_o = head.seq_start;
    assign req_seq_cnt_o   = head.seq_cnt;
    assign req_sid_cnt_o   = head.sid_cnt;

endmodule

// File: tb/tb_miss_msg_det_q.sv
// Directed bench for miss_msg_det_q: a default-width instance for the main
// scenarios and a narrow instance for session wrap and counter saturation.
module tb_miss_msg_det_q;

    logic        clk = 1'b0;
    logic        reset;
    int          errors = 0;
    int          checks = 0;

    // instance A: default widths
    logic        a_v, a_eos, a_rdy;
    logic [79:0] a_sid;
    logic [63:0] a_seq;
    logic [15:0] a_cnt;
    logic        a_req_v, a_kind, a_drop, a_err;
    logic [79:0] a_req_sid, a_req_sid_cnt;
    logic [63:0] a_req_start, a_req_seq_cnt;
    logic [15:0] a_dup, a_gap;

    // instance B: SID_W=8, SEQ_NUM_W=16, CNT_W=2, DEPTH=2
    logic        b_v, b_eos, b_rdy;
    logic [7:0]  b_sid;
    logic [15:0] b_seq;
    logic [15:0] b_cnt;
    logic        b_req_v, b_kind, b_drop, b_err;
    logic [7:0]  b_req_sid, b_req_sid_cnt;
    logic [15:0] b_req_start, b_req_seq_cnt;
    logic [1:0]  b_dup, b_gap;

    always #5 clk = ~clk;

    miss_msg_det_q dut_a (
        .clk(clk), .reset(reset), .v_i(a_v), .sid_i(a_sid), .seq_num_i(a_seq),
        .msg_cnt_i(a_cnt), .eos_i(a_eos), .req_v_o(a_req_v), .req_rdy_i(a_rdy),
        .req_kind_o(a_kind), .req_sid_o(a_req_sid), .req_seq_start_o(a_req_start),
        .req_seq_cnt_o(a_req_seq_cnt), .req_sid_cnt_o(a_req_sid_cnt),
        .dup_cnt_o(a_dup), .gap_cnt_o(a_gap), .drop_o(a_drop), .err_o(a_err)
    );

    miss_msg_det_q #(
        .SEQ_NUM_W(16), .SID_W(8), .ML_W(16), .SID_GAP_MAX(8'd128),
        .SEQ_INIT(16'd1), .DEPTH(2), .CNT_W(2)
    ) dut_b (
        .clk(clk), .reset(reset), .v_i(b_v), .sid_i(b_sid), .seq_num_i(b_seq),
        .msg_cnt_i(b_cnt), .eos_i(b_eos), .req_v_o(b_req_v), .req_rdy_i(b_rdy),
        .req_kind_o(b_kind), .req_sid_o(b_req_sid), .req_seq_start_o(b_req_start),
        .req_seq_cnt_o(b_req_seq_cnt), .req_sid_cnt_o(b_req_sid_cnt),
        .dup_cnt_o(b_dup), .gap_cnt_o(b_gap), .drop_o(b_drop), .err_o(b_err)
    );

    task automatic send_a(input logic [79:0] sid, input logic [63:0] seq,
                          input logic [15:0] cnt, input logic eos);
        @(negedge clk);
        a_v = 1'b1; a_sid = sid; a_seq = seq; a_cnt = cnt; a_eos = eos;
        @(negedge clk);
        a_v = 1'b0; a_eos = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] sid, input logic [15:0] seq,
                          input logic [15:0] cnt, input logic eos);
        @(negedge clk);
        b_v = 1'b1; b_sid = sid; b_seq = seq; b_cnt = cnt; b_eos = eos;
        @(negedge clk);
        b_v = 1'b0; b_eos = 1'b0;
    endtask

    task automatic pop_a();
        @(negedge clk);
        a_rdy = 1'b1;
        @(negedge clk);
        a_rdy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (a_req_v !== 1'b0) begin errors++; $display("FAIL reset_req_v got %0b want 0", a_req_v); end
        checks++; if ({a_kind, a_req_sid, a_req_start, a_req_seq_cnt, a_req_sid_cnt} !== '0) begin errors++; $display("FAIL reset_req_fields got nonzero want 0"); end
        checks++; if (a_dup !== 16'd0 || a_gap !== 16'd0) begin errors++; $display("FAIL reset_counters got dup=%0d gap=%0d want 0 0", a_dup, a_gap); end
        checks++; if (a_drop !== 1'b0 || a_err !== 1'b0) begin errors++; $display("FAIL reset_flags got drop=%0b err=%0b want 0 0", a_drop, a_err); end
        checks++; if (dut_a.seq_q !== 64'd1 || dut_a.sync_q !== 1'b0 || dut_a.sid_q !== 80'd0) begin errors++; $display("FAIL reset_state got seq=%0d sync=%0b sid=%0h want 1 0 0", dut_a.seq_q, dut_a.sync_q, dut_a.sid_q); end
        reset = 1'b0;
    endtask

    task automatic test_inorder();
        send_a(80'd5, 64'd1, 16'd3, 1'b0);
        send_a(80'd5, 64'd4, 16'd2, 1'b0);
        send_a(80'd5, 64'd6, 16'd0, 1'b0);
        checks++; if (a_req_v !== 1'b0) begin errors++; $display("FAIL inorder_no_req got %0b want 0", a_req_v); end
        checks++; if (dut_a.seq_q !== 64'd6 || dut_a.sid_q !== 80'd5) begin errors++; $display("FAIL inorder_state got seq=%0d sid=%0h want 6 5", dut_a.seq_q, dut_a.sid_q); end
        checks++; if (a_gap !== 16'd0) begin errors++; $display("FAIL inorder_gap_cnt got %0d want 0", a_gap); end
        send_a(80'd5, 64'd6, 16'd4, 1'b0);
        checks++; if (dut_a.seq_q !== 64'd10) begin errors++; $display("FAIL inorder_seq10 got %0d want 10", dut_a.seq_q); end
    endtask

    task automatic test_gap();
        send_a(80'd5, 64'd14, 16'd2, 1'b0);
        checks++; if (a_req_v !== 1'b1) begin errors++; $display("FAIL gap_req_v got %0b want 1", a_req_v); end
        checks++; if (a_kind !== 1'b0 || a_req_sid !== 80'd5 || a_req_start !== 64'd10 || a_req_seq_cnt !== 64'd4 || a_req_sid_cnt !== 80'd0)
            begin errors++; $display("FAIL gap_entry got kind=%0b sid=%0h start=%0d cnt=%0d sidcnt=%0h want 0 5 10 4 0", a_kind, a_req_sid, a_req_start, a_req_seq_cnt, a_req_sid_cnt); end
        checks++; if (dut_a.seq_q !== 64'd16 || a_gap !== 16'd1) begin errors++; $display("FAIL gap_state got seq=%0d gap=%0d want 16 1", dut_a.seq_q, a_gap); end
        pop_a();
        checks++; if (a_req_v !== 1'b0) begin errors++; $display("FAIL gap_pop got %0b want 0", a_req_v); end
    endtask

    task automatic test_overlap_dup();
        send_a(80'd5, 64'd14, 16'd4, 1'b0);
        checks++; if (dut_a.seq_q !== 64'd18 || a_req_v !== 1'b0) begin errors++; $display("FAIL overlap got seq=%0d req_v=%0b want 18 0", dut_a.seq_q, a_req_v); end
        send_a(80'd5, 64'd12, 16'd2, 1'b0);
        checks++; if (a_dup !== 16'd1 || dut_a.seq_q !== 64'd18 || a_req_v !== 1'b0) begin errors++; $display("FAIL dup got dup=%0d seq=%0d req_v=%0b want 1 18 0", a_dup, dut_a.seq_q, a_req_v); end
    endtask

    task automatic test_jump();
        send_a(80'd8, 64'd3, 16'd1, 1'b0);
        checks++; if (a_req_v !== 1'b1 || a_kind !== 1'b1 || a_req_sid !== 80'd5 || a_req_start !== 64'd18 || a_req_seq_cnt !== 64'd3 || a_req_sid_cnt !== 80'd3)
            begin errors++; $display("FAIL jump_entry got v=%0b kind=%0b sid=%0h start=%0d cnt=%0d sidcnt=%0h want 1 1 5 18 3 3", a_req_v, a_kind, a_req_sid, a_req_start, a_req_seq_cnt, a_req_sid_cnt); end
        checks++; if (dut_a.sid_q !== 80'd8 || dut_a.seq_q !== 64'd4 || a_gap !== 16'd2) begin errors++; $display("FAIL jump_state got sid=%0h seq=%0d gap=%0d want 8 4 2", dut_a.sid_q, dut_a.seq_q, a_gap); end
        pop_a();
    endtask

    task automatic test_eos_stale();
        send_a(80'd8, 64'd4, 16'd0, 1'b1);
        checks++; if (dut_a.sid_q !== 80'd9 || dut_a.seq_q !== 64'd1 || a_req_v !== 1'b0) begin errors++; $display("FAIL eos got sid=%0h seq=%0d req_v=%0b want 9 1 0", dut_a.sid_q, dut_a.seq_q, a_req_v); end
        send_a(80'd7, 64'd1, 16'd1, 1'b0);
        checks++; if (a_dup !== 16'd2 || a_req_v !== 1'b0 || dut_a.sid_q !== 80'd9 || dut_a.seq_q !== 64'd1)
            begin errors++; $display("FAIL stale got dup=%0d req_v=%0b sid=%0h seq=%0d want 2 0 9 1", a_dup, a_req_v, dut_a.sid_q, dut_a.seq_q); end
    endtask

    task automatic test_fifo_full();
        logic [63:0] exp_start [3];
        exp_start[0] = 64'd7; exp_start[1] = 64'd10; exp_start[2] = 64'd16;
        for (int i = 0; i < 5; i++) send_a(80'd9, 64'(3 + 3 * i), 16'd1, 1'b0);
        checks++; if (a_drop !== 1'b1 || a_gap !== 16'd7 || dut_a.seq_q !== 64'd16) begin errors++; $display("FAIL full_drop got drop=%0b gap=%0d seq=%0d want 1 7 16", a_drop, a_gap, dut_a.seq_q); end
        checks++; if (a_req_v !== 1'b1 || a_req_start !== 64'd1 || a_req_seq_cnt !== 64'd2) begin errors++; $display("FAIL full_head got v=%0b start=%0d cnt=%0d want 1 1 2", a_req_v, a_req_start, a_req_seq_cnt); end
        // pop and push on the same edge while full
        @(negedge clk);
        a_rdy = 1'b1; a_v = 1'b1; a_sid = 80'd9; a_seq = 64'd18; a_cnt = 16'd1; a_eos = 1'b0;
        @(negedge clk);
        a_v = 1'b0;
        checks++; if (a_req_v !== 1'b1 || a_req_start !== 64'd4 || a_gap !== 16'd8) begin errors++; $display("FAIL full_popush got v=%0b start=%0d gap=%0d want 1 4 8", a_req_v, a_req_start, a_gap); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (a_req_v !== 1'b1 || a_req_start !== exp_start[i] || a_req_seq_cnt !== 64'd2)
                begin errors++; $display("FAIL drain_%0d got v=%0b start=%0d cnt=%0d want 1 %0d 2", i, a_req_v, a_req_start, a_req_seq_cnt, exp_start[i]); end
        end
        @(negedge clk);
        a_rdy = 1'b0;
        checks++; if (a_req_v !== 1'b0 || a_req_start !== 64'd0) begin errors++; $display("FAIL drain_empty got v=%0b start=%0d want 0 0", a_req_v, a_req_start); end
    endtask

    task automatic test_overflow();
        send_a(80'd9, 64'hFFFF_FFFF_FFFF_FFFF, 16'd1, 1'b0);
        checks++; if (a_err !== 1'b1 || dut_a.seq_q !== 64'd19 || a_req_v !== 1'b0 || a_gap !== 16'd8)
            begin errors++; $display("FAIL overflow got err=%0b seq=%0d req_v=%0b gap=%0d want 1 19 0 8", a_err, dut_a.seq_q, a_req_v, a_gap); end
        send_a(80'd9, 64'hFFFF_FFFF_FFFF_FFFF, 16'd0, 1'b0);
        checks++; if (dut_a.seq_q !== 64'hFFFF_FFFF_FFFF_FFFF || a_gap !== 16'd9) begin errors++; $display("FAIL no_overflow got seq=%0h gap=%0d want ffffffffffffffff 9", dut_a.seq_q, a_gap); end
    endtask

    task automatic test_sid_wrap_sat();
        send_b(8'd255, 16'd1, 16'd1, 1'b1);
        checks++; if (dut_b.sid_q !== 8'd0 || dut_b.seq_q !== 16'd1) begin errors++; $display("FAIL wrap_eos got sid=%0d seq=%0d want 0 1", dut_b.sid_q, dut_b.seq_q); end
        send_b(8'd1, 16'd5, 16'd1, 1'b0);
        checks++; if (b_req_v !== 1'b1 || b_kind !== 1'b1 || b_req_sid !== 8'd0 || b_req_start !== 16'd1 || b_req_seq_cnt !== 16'd5 || b_req_sid_cnt !== 8'd1)
            begin errors++; $display("FAIL wrap_jump got v=%0b kind=%0b sid=%0d start=%0d cnt=%0d sidcnt=%0d want 1 1 0 1 5 1", b_req_v, b_kind, b_req_sid, b_req_start, b_req_seq_cnt, b_req_sid_cnt); end
        for (int i = 0; i < 4; i++) send_b(8'd0, 16'd1, 16'd1, 1'b0);
        checks++; if (b_dup !== 2'd3 || dut_b.sid_q !== 8'd1 || dut_b.seq_q !== 16'd6) begin errors++; $display("FAIL dup_sat got dup=%0d sid=%0d seq=%0d want 3 1 6", b_dup, dut_b.sid_q, dut_b.seq_q); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        a_v = 1'b0; a_eos = 1'b0; a_rdy = 1'b0; a_sid = '0; a_seq = '0; a_cnt = '0;
        b_v = 1'b0; b_eos = 1'b0; b_rdy = 1'b0; b_sid = '0; b_seq = '0; b_cnt = '0;
        test_reset();
        test_inorder();
        test_gap();
        test_overlap_dup();
        test_jump();
        test_eos_stale();
        test_fifo_full();
        test_overflow();
        test_sid_wrap_sat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/miss_msg_det_q.md
Name: miss_msg_det_q

Overview:
- Second-generation MoldUDP64 missing-message detector.
- Tracks the next expected (session id, sequence number) and classifies every received packet as in-order, gap, overlap, stale/duplicate or session jump.
- Queues each detected hole as a retransmission-request entry in a parametrised FIFO with a valid/ready output, so the request generator is decoupled from line rate.
- Sits between the MoldUDP64 header parser and the retransmission request builder.

Parameters:
- SEQ_NUM_W, 64, sequence number width.
- SID_W, 80, session id width.
- ML_W, 16, message count width.
- SID_GAP_MAX, 2**(SID_W-1), a forward session distance at or above this value is treated as stale, not as a jump.
- SEQ_INIT, 1, first sequence number of a new session.
- DEPTH, 4, request FIFO depth; power of 2, at least 2.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- v_i, in, 1, packet header valid; one packet per cycle; no backpressure.
- sid_i, in, SID_W, packet session id.
- seq_num_i, in, SEQ_NUM_W, packet sequence number.
- msg_cnt_i, in, ML_W, packet message count; 0 means heartbeat.
- eos_i, in, 1, end-of-session packet.
- req_v_o, out, 1, request entry valid.
- req_rdy_i, in, 1, consumer ready.
- req_kind_o, out, 1, 0 = SEQ (gap inside one session), 1 = SID (gap spans sessions).
- req_sid_o, out, SID_W, session of the first missing message.
- req_seq_start_o, out, SEQ_NUM_W, first missing sequence number.
- req_seq_cnt_o, out, SEQ_NUM_W. SEQ entries: number of missing messages. SID entries: the received seq_num_i in the new session, which is the exclusive end of the hole in that session.
- req_sid_cnt_o, out, SID_W, SID entries only: sid_i - sid_q. Value is 0 for SEQ entries.
- dup_cnt_o, out, CNT_W, count of stale or duplicate packets; saturating.
- gap_cnt_o, out, CNT_W, count of detected gaps; saturating.
- drop_o, out, 1, sticky flag: a request was lost because the FIFO was full.
- err_o, out, 1, sticky flag: seq_num_i + msg_cnt_i overflowed SEQ_NUM_W.

Behaviour:
- State registers:
  - sync_q: reset 0.
  - sid_q: reset 0.
  - seq_q: next expected sequence number; reset SEQ_INIT.
- Outputs after reset: FIFO empty; req_v_o=0; all req fields 0; both counters 0; both sticky flags 0.
- end = seq_num_i + msg_cnt_i, computed SEQ_NUM_W+1 wide.
  - If the carry bit is set: set err_o and ignore the packet; no state change, no push.
- First valid packet after reset (sync_q=0): sid_q<=sid_i, seq_q<=end, sync_q<=1; no request pushed.
- With sync_q=1, classify each valid packet. Use sdist = sid_i - sid_q (mod 2^SID_W). Sequence compares are unsigned.
  - Stale: sdist != 0 and sdist >= SID_GAP_MAX. Increment dup_cnt; no state change.
  - Same session (sdist == 0):
    - end <= seq_q and msg_cnt_i != 0: duplicate. Increment dup_cnt; no state change.
    - seq_num_i > seq_q: gap. Push SEQ{sid_q, seq_q, cnt=seq_num_i-seq_q}; increment gap_cnt; seq_q<=end.
    - Otherwise (in-order, overlap or heartbeat): seq_q<=max(seq_q, end); no push.
  - Jump (0 < sdist < SID_GAP_MAX): push SID{sid_q, seq_q, seq_cnt=seq_num_i, sid_cnt=sdist}; increment gap_cnt; sid_q<=sid_i; seq_q<=end.
- eos_i on an accepted (non-stale) packet overrides the state update above: sid_q<=sid_q_new+1 (wraps mod 2^SID_W); seq_q<=SEQ_INIT. Any push for that packet still happens.
- Timing:
  - Classification is combinational from inputs and state; state and FIFO write update on the same edge.
  - A pushed entry appears on req_* one cycle later. There is no bypass.
- FIFO rules:
  - Outputs show the head entry. A pop occurs when req_v_o & req_rdy_i.
  - A push is accepted when not full, or when full and popping in the same cycle.
  - A push while full with no pop is dropped and sets drop_o. Detector state still advances.
  - Simultaneous push and pop on an empty FIFO is impossible, because req_v_o=0 when empty.
- Counters hold at all-ones.
- reset mid-operation: FIFO contents discarded, all state returns to reset values on the next edge.

Decomposition:
- Package miss_msg_det_pkg:
  - req_kind_e enum (SEQ, SID).
  - miss_req_t struct (kind, sid, seq_start, seq_cnt, sid_cnt).
  - Width constants.
- One sub-module: miss_req_fifo, a synchronous FIFO of miss_req_t parametrised by DEPTH, with full/empty and push/pop.

Test Plan:
- Sync then in-order: (sid 5, seq 1, cnt 3), (5, 4, 2), (5, 6, 0) -> no req_v_o; seq_q=6; gap_cnt=0.
- Same-session gap: after expecting (5, 10), send (5, 14, 2) -> one cycle later SEQ{5, 10, cnt 4}; seq_q=16; gap_cnt=1.
- Overlap and duplicate:
  - Expect 16; send (5, 14, 4) -> seq_q=18, no push.
  - Then send (5, 12, 2) -> dup_cnt=1.
- Session jump: expecting (5, 18), send (8, 3, 1) -> SID{sid 5, seq 18, seq_cnt 3, sid_cnt 3}; sid_q=8; seq_q=4.
- eos and stale:
  - (8, 4, 0, eos) -> sid_q=9, seq_q=1.
  - Then (7, 1, 1) -> dup_cnt increments, no push.
  - With SID_W=8: sid_q=255, eos -> sid_q=0.
- FIFO full (DEPTH=4, req_rdy_i=0): 5 gaps -> 4 entries held, drop_o=1.
  - Then req_rdy_i=1 with a gap packet on the same cycle -> pop and push both succeed; entries drain in order.
